// File: rtl/zynq_axi3_burst_mem_if.sv
// AXI3 slave-port bundle for zynq_axi3_burst_mem. The master modport is the
// PL-side requester; the slave modport is the burst memory.
interface zynq_axi3_burst_mem_if #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32
);
  // Write address channel
  logic [addr_width_p-1:0]   awaddr;
  logic [5:0]                awid;
  logic [3:0]                awlen;
  logic                      awvalid;
  logic                      awready;
  // Write data channel
  logic [data_width_p-1:0]   wdata;
  logic [data_width_p/8-1:0] wstrb;
  logic                      wlast;
  logic                      wvalid;
  logic                      wready;
  // Write response channel
  logic [5:0]                bid;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  // Read address channel
  logic [addr_width_p-1:0]   araddr;
  logic [5:0]                arid;
  logic [3:0]                arlen;
  logic                      arvalid;
  logic                      arready;
  // Read data channel
  logic [data_width_p-1:0]   rdata;
  logic [5:0]                rid;
  logic [1:0]                rresp;
  logic                      rlast;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awaddr, awid, awlen, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output araddr, arid, arlen, arvalid, input arready,
    input  rdata, rid, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awaddr, awid, awlen, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  araddr, arid, arlen, arvalid, output arready,
    output rdata, rid, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/zynq_axi3_burst_mem.sv
// AXI3 burst slave memory. One transaction in flight at a time; INCR bursts
// of 1-16 beats over a word-addressed RAM with byte strobes. Write and read
// address requests that collide in IDLE are granted alternately.
module zynq_axi3_burst_mem #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32,
  parameter int els_p        = 4096
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  zynq_axi3_burst_mem_if.slave s_axi
);

  localparam int idx_w_lp  = $clog2(els_p);
  localparam int strb_w_lp = data_width_p / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    WRESP = 2'd2,
    RDATA = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  pref_w_q, pref_w_d;
  logic [idx_w_lp-1:0]   idx_q, idx_d;
  logic [3:0]            len_q, len_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [5:0]            id_q, id_d;
  logic                  err_q, err_d;
  logic [data_width_p-1:0] rdata_q;

  logic [data_width_p-1:0] mem [els_p];

  logic                  aw_ready, ar_ready;
  logic                  collide, at_last, w_hs;
  logic [idx_w_lp-1:0]   aw_idx, ar_idx, idx_inc;
  logic                  mem_we;
  logic [strb_w_lp-1:0]  mem_be;
  logic                  rd_en;
  logic [idx_w_lp-1:0]   rd_idx;
  logic                  unused_addr_bits;

  // Word index comes from the bits just above the byte offset; the upper
  // address bits alias onto the same RAM.
  assign aw_idx  = s_axi.awaddr[2 +: idx_w_lp];
  assign ar_idx  = s_axi.araddr[2 +: idx_w_lp];
  assign idx_inc = idx_q + idx_w_lp'(1);
  assign unused_addr_bits = ^{s_axi.awaddr, s_axi.araddr};

  // Address-channel grants are only offered from IDLE and out of reset.
  assign collide  = aresetn && (state_q == IDLE) && s_axi.awvalid && s_axi.arvalid;
  assign aw_ready = aresetn && (state_q == IDLE) && s_axi.awvalid
                    && (!s_axi.arvalid || pref_w_q);
  assign ar_ready = aresetn && (state_q == IDLE) && s_axi.arvalid && !aw_ready;
  assign at_last  = (cnt_q == len_q);
  assign w_hs     = aresetn && (state_q == WDATA) && s_axi.wvalid;

  // Outputs depend only on registered state (plus the AW/AR valids for grants).
  assign s_axi.awready = aw_ready;
  assign s_axi.arready = ar_ready;
  assign s_axi.wready  = (state_q == WDATA);
  assign s_axi.bvalid  = (state_q == WRESP);
  assign s_axi.bid     = id_q;
  assign s_axi.bresp   = err_q ? 2'b10 : 2'b00;
  assign s_axi.rvalid  = (state_q == RDATA);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rid     = id_q;
  assign s_axi.rresp   = 2'b00;
  assign s_axi.rlast   = (state_q == RDATA) && at_last;

  // Next-state, burst bookkeeping and RAM port control.
  always_comb begin
    state_d  = state_q;
    pref_w_d = pref_w_q;
    idx_d    = idx_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    id_d     = id_q;
    err_d    = err_q;
    mem_we   = 1'b0;
    mem_be   = '0;
    rd_en    = 1'b0;
    rd_idx   = '0;
    unique case (state_q)
      IDLE: begin
        if (collide) begin
          pref_w_d = ~pref_w_q;
        end
        if (aw_ready) begin
          id_d    = s_axi.awid;
          len_d   = s_axi.awlen;
          idx_d   = aw_idx;
          cnt_d   = 4'd0;
          err_d   = 1'b0;
          state_d = WDATA;
        end else if (ar_ready) begin
          id_d    = s_axi.arid;
          len_d   = s_axi.arlen;
          idx_d   = ar_idx;
          cnt_d   = 4'd0;
          rd_en   = 1'b1;
          rd_idx  = ar_idx;
          state_d = RDATA;
        end
      end
      WDATA: begin
        if (w_hs) begin
          mem_we = 1'b1;
          mem_be = s_axi.wstrb;
          idx_d  = idx_inc;
          cnt_d  = cnt_q + 4'd1;
          // The beat count, not wlast, ends the burst; a misplaced or
          // missing wlast is reported through bresp.
          if (s_axi.wlast != at_last) begin
            err_d = 1'b1;
          end
          if (at_last) begin
            state_d = WRESP;
          end
        end
      end
      WRESP: begin
        if (s_axi.bready) begin
          state_d = IDLE;
        end
      end
      RDATA: begin
        if (s_axi.rready) begin
          if (at_last) begin
            state_d = IDLE;
          end else begin
            idx_d  = idx_inc;
            cnt_d  = cnt_q + 4'd1;
            rd_en  = 1'b1;
            rd_idx = idx_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and burst state registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      pref_w_q <= 1'b1;
      idx_q    <= '0;
      len_q    <= 4'd0;
      cnt_q    <= 4'd0;
      id_q     <= 6'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pref_w_q <= pref_w_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      err_q    <= err_d;
    end
  end

  // RAM byte-lane writes; contents survive reset.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < strb_w_lp; b++) begin
        if (mem_be[b]) begin
          mem[idx_q][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
        end
      end
    end
  end

  // Registered RAM read: prefetches the beat that R presents next, so
  // rdata holds steady while the master stalls.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= mem[rd_idx];
    end
  end

endmodule
